sfft_butterfly_sequencer: RTL
=============================

# sfft_butterfly_sequencer

Control block that drives the SFFT butterfly datapath. For every stage it walks the butterflies in order, reading the twiddle index (k) and the A/B element indexes from the kValues/index ROM, and issues those indexes as read addresses to a ping-pong pair of pipeline buffer RAMs. It then delays the same indexes to the butterfly output, where they become the write-back addresses into the opposite bank. It is the reader/consumer of the ROM and buffer RAM and sits between those memories and the butterfly unit.

## Interface
Parameters:
- NFFT, 512, transform size (power of two)
- NFFT_LOG2, 9, log2(NFFT); this is also the number of stages
- BFLY_LATENCY, 3, butterfly pipeline depth in cycles (≥1)
- ROM_ADDR_W, $clog2(NFFT_LOG2*NFFT/2), ROM address width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse at transform completion
- resultBank  out  1  bank holding the final result, equal to NFFT_LOG2 mod 2 (constant)
- romAddress  out  ROM_ADDR_W  stage*(NFFT/2)+butterfly
- romAIndex, romBIndex, romK  in  NFFT_LOG2 each  ROM data, valid 1 cycle after romAddress
- readBank  out  1  bank being read; write bank = ~readBank
- readAddrA, readAddrB  out  NFFT_LOG2  buffer read addresses
- kValue  out  NFFT_LOG2  twiddle index, aligned with RAM read data
- bflyInValid  out  1  RAM data and kValue valid into the butterfly this cycle
- writeAddrA, writeAddrB  out  NFFT_LOG2  write-back addresses
- writeEnable  out  1  write butterfly results to the write bank

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: the block waits. On start, stage=0, bfly=0, readBank=0, and the next state is ISSUE.
- ISSUE: each cycle, romAddress = stage*(NFFT/2)+bfly and issueValid=1, then bfly increments. After issuing bfly = NFFT/2−1, the next state is DRAIN.
- Pipeline, with t as the issue cycle:
  - t+1: readAddrA/B = romAIndex/romBIndex (combinational pass-through, gated to 0 when the tap is invalid). The triple (aIndex, bIndex, k) is captured into the delay line.
  - t+2: kValue and bflyInValid are asserted.
  - t+2+BFLY_LATENCY: writeAddrA/B and writeEnable are asserted.
- DRAIN: lasts exactly 2+BFLY_LATENCY cycles, so the last write of the stage lands in the final DRAIN cycle. On exit:
  - If stage = NFFT_LOG2−1, the next state is DONE.
  - Otherwise stage increments, bfly is set to 0, readBank toggles, and the next state is ISSUE.
- DONE: done=1 for one cycle, then IDLE.
- The stage drains before the bank swap, so a read never overlaps a write of the same data.
- start while not in IDLE is ignored.
- Arithmetic: romAddress is computed unsigned at ROM_ADDR_W bits with no truncation. The bfly counter is NFFT_LOG2−1 bits and its wrap is the end-of-stage event.

## Timing
- Reset values: all outputs 0 and state IDLE; resultBank is constant.
- Reset asserted mid-transform: on the next edge every output is 0, the delay line is cleared (no stray writeEnable), and the state is IDLE.
- Cycles per stage: NFFT/2 + 2 + BFLY_LATENCY.
- Timeline: start at cycle 0 gives the first ISSUE at cycle 1, and done at cycle 1 + NFFT_LOG2*(NFFT/2+2+BFLY_LATENCY).
- Within ISSUE, bflyInValid and writeEnable are contiguous, with no bubbles.
- start asserted in the same cycle as done is ignored. start one cycle after done is accepted.

## Structure
- Shared package sfft_pkg holds:
  - the typedef state_t (IDLE/ISSUE/DRAIN/DONE)
  - ROM_ADDR_W and related helpers, derived from the global NFFT/nFFT macros in global_variables.sv
  - constants: PIPE_DEPTH = 2+BFLY_LATENCY
- Sub-module sfft_index_delay_line: a parameterized shift register carrying {valid, aIndex, bIndex, k}. It has taps for t+2 (kValue) and t+2+BFLY_LATENCY (write-back) and is cleared synchronously by reset_n.

## Test plan
- NFFT=8, BFLY_LATENCY=3, start at cycle 0 -> per-stage length 9, done at cycle 28, resultBank=1, readBank sequence 0,1,0.
- Behavioral ROM model returning aIndex=bfly, bIndex=bfly+4, k=stage -> writeAddrA/B = romAIndex/romBIndex delayed by exactly BFLY_LATENCY+1 cycles after readAddrA/B, and kValue = stage at bflyInValid.
- Scoreboard over a full transform -> exactly NFFT_LOG2*NFFT/2 = 12 writeEnable cycles, and no writeEnable during a cycle where readBank changes.
- start pulsed at cycles 5 and 20 during busy -> ignored, single done.
- reset_n low at cycle 14 (mid-DRAIN) -> next cycle writeEnable=0, busy=0, state IDLE; a new start yields a full 28-cycle run.
- Back-to-back: start in the cycle after done -> second transform begins at the next cycle with stage=0 and readBank=0.

Source files
------------

// File: rtl/sfft_pkg.sv
// Shared types and sizing helpers for the SFFT butterfly control path.
package sfft_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_t;

    localparam int unsigned DEFAULT_NFFT         = 512;
    localparam int unsigned DEFAULT_NFFT_LOG2    = $clog2(DEFAULT_NFFT);
    localparam int unsigned DEFAULT_BFLY_LATENCY = 3;

    // One cycle of ROM access plus one of RAM read, then the butterfly itself.
    function automatic int unsigned pipe_depth(input int unsigned bfly_latency);
        return 2 + bfly_latency;
    endfunction

    function automatic int unsigned rom_addr_width(input int unsigned nfft,
                                                   input int unsigned nfft_log2);
        return $clog2(nfft_log2 * nfft / 2);
    endfunction

    localparam int unsigned PIPE_DEPTH = pipe_depth(DEFAULT_BFLY_LATENCY);
    localparam int unsigned DEFAULT_ROM_ADDR_W =
        rom_addr_width(DEFAULT_NFFT, DEFAULT_NFFT_LOG2);

endpackage

// File: rtl/sfft_index_delay_line.sv
// Shift register carrying {valid, aIndex, bIndex, k} from RAM read to butterfly
// input (tap 0) and on to write-back (tap Latency).
module sfft_index_delay_line #(
    parameter int unsigned IdxW    = 9,
    parameter int unsigned Latency = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid_i,
    input  logic [IdxW-1:0] in_a_i,
    input  logic [IdxW-1:0] in_b_i,
    input  logic [IdxW-1:0] in_k_i,
    output logic            bfly_valid_o,
    output logic [IdxW-1:0] bfly_k_o,
    output logic            wb_valid_o,
    output logic [IdxW-1:0] wb_a_o,
    output logic [IdxW-1:0] wb_b_o
);

    localparam int unsigned Depth  = Latency + 1;
    localparam int unsigned EntryW = 1 + 3 * IdxW;

    logic [EntryW-1:0] pipe_q [Depth];
    logic [EntryW-1:0] pipe_d [Depth];

    always_comb begin
        pipe_d[0] = {in_valid_i, in_a_i, in_b_i, in_k_i};
        for (int i = 1; i < Depth; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bfly_valid_o = pipe_q[0][EntryW-1];
    assign bfly_k_o     = pipe_q[0][IdxW-1:0];
    assign wb_valid_o   = pipe_q[Depth-1][EntryW-1];
    assign wb_a_o       = pipe_q[Depth-1][3*IdxW-1:2*IdxW];
    assign wb_b_o       = pipe_q[Depth-1][2*IdxW-1:IdxW];

endmodule

// File: rtl/sfft_butterfly_sequencer.sv
// Walks every stage/butterfly of the SFFT, issuing ROM and ping-pong buffer
// addresses and delaying the indexes to the butterfly write-back.
module sfft_butterfly_sequencer
    import sfft_pkg::*;
#(
    parameter int unsigned NFFT         = DEFAULT_NFFT,
    parameter int unsigned NFFT_LOG2    = DEFAULT_NFFT_LOG2,
    parameter int unsigned BFLY_LATENCY = DEFAULT_BFLY_LATENCY,
    parameter int unsigned ROM_ADDR_W   = rom_addr_width(NFFT, NFFT_LOG2)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  resultBank,
    output logic [ROM_ADDR_W-1:0] romAddress,
    input  logic [NFFT_LOG2-1:0]  romAIndex,
    input  logic [NFFT_LOG2-1:0]  romBIndex,
    input  logic [NFFT_LOG2-1:0]  romK,
    output logic                  readBank,
    output logic [NFFT_LOG2-1:0]  readAddrA,
    output logic [NFFT_LOG2-1:0]  readAddrB,
    output logic [NFFT_LOG2-1:0]  kValue,
    output logic                  bflyInValid,
    output logic [NFFT_LOG2-1:0]  writeAddrA,
    output logic [NFFT_LOG2-1:0]  writeAddrB,
    output logic                  writeEnable
);

    localparam int unsigned BflyW  = NFFT_LOG2 - 1;
    localparam int unsigned StageW = (NFFT_LOG2 > 1) ? $clog2(NFFT_LOG2) : 1;
    localparam int unsigned Depth  = pipe_depth(BFLY_LATENCY);
    localparam int unsigned DrainW = $clog2(Depth + 1);

    state_t              state_q, state_d;
    logic [StageW-1:0]   stage_q, stage_d;
    logic [BflyW-1:0]    bfly_q, bfly_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic                read_bank_q, read_bank_d;
    logic                rd_valid_q, rd_valid_d;
    logic                issue_valid;

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        bfly_d      = bfly_q;
        drain_d     = drain_q;
        read_bank_d = read_bank_q;
        issue_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    stage_d     = '0;
                    bfly_d      = '0;
                    read_bank_d = 1'b0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                issue_valid = 1'b1;
                busy        = 1'b1;
                // bfly wraps to zero on the last butterfly of the stage
                bfly_d      = bfly_q + 1'b1;
                if (bfly_q == '1) begin
                    drain_d = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                busy    = 1'b1;
                drain_d = drain_q + 1'b1;
                if (drain_q == DrainW'(Depth - 1)) begin
                    drain_d = '0;
                    if (stage_q == StageW'(NFFT_LOG2 - 1)) begin
                        state_d = StDone;
                    end else begin
                        stage_d     = stage_q + 1'b1;
                        bfly_d      = '0;
                        read_bank_d = ~read_bank_q;
                        state_d     = StIssue;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        rd_valid_d = issue_valid;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            stage_q     <= '0;
            bfly_q      <= '0;
            drain_q     <= '0;
            read_bank_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            bfly_q      <= bfly_d;
            drain_q     <= drain_d;
            read_bank_q <= read_bank_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign resultBank = 1'(NFFT_LOG2 % 2);
    assign readBank   = read_bank_q;
    assign romAddress = issue_valid
        ? ROM_ADDR_W'(stage_q) * ROM_ADDR_W'(NFFT / 2) + ROM_ADDR_W'(bfly_q)
        : '0;

    // ROM data arrives one cycle after issue and goes straight out as RAM addresses.
    assign readAddrA = rd_valid_q ? romAIndex : '0;
    assign readAddrB = rd_valid_q ? romBIndex : '0;

    logic [NFFT_LOG2-1:0] rd_k;
    assign rd_k = rd_valid_q ? romK : '0;

    sfft_index_delay_line #(
        .IdxW    (NFFT_LOG2),
        .Latency (BFLY_LATENCY)
    ) u_delay_line (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid_i   (rd_valid_q),
        .in_a_i       (readAddrA),
        .in_b_i       (readAddrB),
        .in_k_i       (rd_k),
        .bfly_valid_o (bflyInValid),
        .bfly_k_o     (kValue),
        .wb_valid_o   (writeEnable),
        .wb_a_o       (writeAddrA),
        .wb_b_o       (writeAddrB)
    );

endmodule
